// File: rtl/mult_arbiter_if.sv
// Request/response and multiplier-side signals of the shared-multiplier arbiter.
// slave is the arbiter's view; master is the requester/multiplier environment.
interface mult_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [15:0] resp_result;
  logic        resp_err;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_done;
  logic [15:0] mul_result;
  logic        busy;
  logic [1:0]  grant_id;

  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_result,
    output req_ready, resp_valid, resp_result, resp_err, mul_start, mul_a, mul_b, busy, grant_id
  );

  modport master (
    output req_valid, req_a, req_b, mul_done, mul_result,
    input  req_ready, resp_valid, resp_result, resp_err, mul_start, mul_a, mul_b, busy, grant_id
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 8x8 multiplier among four requesters, one operation
// in flight at a time, with a WAIT timeout that returns an error response.
module mult_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [1:0]  last_grant_q;
  logic [1:0]  grant_q;
  logic [7:0]  mul_a_q;
  logic [7:0]  mul_b_q;
  logic [7:0]  wait_cnt_q;
  logic        mul_start_q;
  logic        busy_q;
  logic [3:0]  resp_valid_q;
  logic [15:0] resp_result_q;
  logic        resp_err_q;

  logic        grant_found;
  logic [1:0]  grant_idx;

  // Search last_grant+1 .. last_grant+4; 2-bit wrap makes the fourth step last_grant itself.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    for (int k = 1; k <= 4; k++) begin
      if (!grant_found && bus.req_valid[last_grant_q + 2'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = last_grant_q + 2'(k);
      end
    end
  end

  always_comb begin
    bus.req_ready = 4'b0000;
    if (rst_n && (state_q == StIdle) && grant_found) begin
      bus.req_ready = 4'b0001 << grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_grant_q  <= 2'd3;
      grant_q       <= 2'd0;
      mul_a_q       <= 8'd0;
      mul_b_q       <= 8'd0;
      wait_cnt_q    <= 8'd0;
      mul_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      resp_valid_q  <= 4'b0000;
      resp_result_q <= 16'd0;
      resp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            mul_a_q      <= bus.req_a[{grant_idx, 3'b000} +: 8];
            mul_b_q      <= bus.req_b[{grant_idx, 3'b000} +: 8];
            grant_q      <= grant_idx;
            last_grant_q <= grant_idx;
            mul_start_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          mul_start_q <= 1'b0;
          wait_cnt_q  <= 8'd0;
          state_q     <= StWait;
        end
        StWait: begin
          // A done on the final allowed cycle still wins over the timeout.
          if (bus.mul_done) begin
            resp_result_q <= bus.mul_result;
            resp_err_q    <= 1'b0;
            resp_valid_q  <= 4'b0001 << grant_q;
            state_q       <= StResp;
          end else if (wait_cnt_q == TimeoutLast) begin
            wait_cnt_q    <= wait_cnt_q + 8'd1;
            resp_result_q <= 16'd0;
            resp_err_q    <= 1'b1;
            resp_valid_q  <= 4'b0001 << grant_q;
            state_q       <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StResp: begin
          resp_valid_q <= 4'b0000;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.mul_start   = mul_start_q;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: 4-cycle multiplier model, round-robin reference
// model, directed boundary/timeout/reset steps plus randomized operations.
module tb_mult_arbiter;

  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_arbiter_if bus ();

  mult_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Multiplier model: start sampled into stage 1, done one cycle after stage 3.
  logic        mul_en = 1'b1;
  logic        inject = 1'b0;
  logic        s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, s4 = 1'b0;
  logic [15:0] p1 = '0, p2 = '0, p3 = '0, p4 = '0;
  always @(posedge clk) begin
    s1 <= bus.mul_start;
    p1 <= 16'(bus.mul_a) * 16'(bus.mul_b);
    s2 <= s1; p2 <= p1;
    s3 <= s2; p3 <= p2;
    s4 <= s3; p4 <= p3;
  end
  assign bus.mul_done   = (s4 && mul_en) || inject;
  assign bus.mul_result = p4;

  int errors = 0;
  int checks = 0;
  int model_last = 3;
  time prev_acc = 0;
  bit  period_armed = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      int c = (model_last + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Entered and left at posedge+1 of an IDLE cycle.
  task automatic run_op(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input bit to_mode);
    int          g;
    logic [7:0]  ea, eb;
    logic [3:0]  oh;
    bit          seen;
    int          exp_lat;
    g       = model_pick(v);
    ea      = 8'(a >> (8 * g));
    eb      = 8'(b >> (8 * g));
    oh      = 4'(1 << g);
    exp_lat = to_mode ? int'(TO) + 2 : 6;
    mul_en  = !to_mode;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    check("req_ready_grant", 32'(bus.req_ready), 32'(oh));
    @(posedge clk); #1;
    model_last = g;
    if (hold && period_armed) check("accept_period", 32'($time - prev_acc), 32'd70);
    prev_acc = $time;
    period_armed = hold;
    seen = 1'b0;
    for (int lat = 1; lat <= 30 && !seen; lat++) begin
      if (lat > 1) begin @(posedge clk); #1; end
      if (!hold) begin
        bus.req_valid = 4'($urandom);
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
      end
      @(negedge clk);
      check("busy_ready_zero", 32'(bus.req_ready), 32'd0);
      check("mul_start", 32'(bus.mul_start), 32'(lat == 1));
      check("mul_a_stable", 32'(bus.mul_a), 32'(ea));
      check("mul_b_stable", 32'(bus.mul_b), 32'(eb));
      check("busy_high", 32'(bus.busy), 32'd1);
      check("grant_id", 32'(bus.grant_id), 32'(g));
      if (bus.resp_valid !== 4'b0000) begin
        seen = 1'b1;
        check("resp_latency", 32'(lat), 32'(exp_lat));
        check("resp_valid", 32'(bus.resp_valid), 32'(oh));
        check("resp_result", 32'(bus.resp_result), to_mode ? 32'd0 : 32'(16'(ea) * 16'(eb)));
        check("resp_err", 32'(bus.resp_err), 32'(to_mode));
      end
    end
    if (!seen) check("resp_never_seen", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 4'b0000;
    check("idle_resp_clear", 32'(bus.resp_valid), 32'd0);
    check("idle_busy_low", 32'(bus.busy), 32'd0);
    check("idle_grant_hold", 32'(bus.grant_id), 32'(g));
    mul_en = 1'b1;
  endtask

  task automatic do_reset(input logic [3:0] v);
    bus.req_valid = v;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_result", 32'(bus.resp_result), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_mul_start", 32'(bus.mul_start), 32'd0);
    check("rst_mul_ab", {16'd0, bus.mul_a, bus.mul_b}, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_last = 3;
    period_armed = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 4'b0000;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // Reset with all requests pending, then fairness with requests held high.
    do_reset(4'hF);
    for (int i = 0; i < 5; i++) begin
      run_op(4'hF, $urandom, $urandom, 1'b1, 1'b0);
      check("fair_order", 32'(model_last), 32'(i % 4));
    end
    bus.req_valid = 4'b0000;

    do_reset(4'b0000);
    run_op(4'b0001, 32'h0000_000C, 32'h0000_000A, 1'b0, 1'b0);
    run_op(4'b0100, 32'h00FF_0000, 32'h00FF_0000, 1'b0, 1'b0);
    run_op(4'b0100, 32'h0000_0000, 32'h00FF_0000, 1'b0, 1'b0);

    // Timeout, then a late done pulse in IDLE must be ignored.
    run_op(4'b1000, $urandom, $urandom, 1'b0, 1'b1);
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_done_resp", 32'(bus.resp_valid), 32'd0);
      check("late_done_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
    end

    // Reset in the middle of WAIT.
    bus.req_valid = 4'b0010;
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_last = 3;
    period_armed = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_mul_start", 32'(bus.mul_start), 32'd0);
    check("midrst_mul_ab", {16'd0, bus.mul_a, bus.mul_b}, 32'd0);
    check("midrst_grant", 32'(bus.grant_id), 32'd0);
    check("midrst_result", {15'd0, bus.resp_err, bus.resp_result}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_op(4'hF, $urandom, $urandom, 1'b0, 1'b0);
    check("midrst_first_req0", 32'(model_last), 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_op(4'($urandom_range(1, 15)), $urandom, $urandom, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, with all state updated on its rising edge; reset SHALL be rst_n, synchronous and active-low.
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT cycles allowed before an operation is aborted; legal range 6..255.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 req_valid  input  4  per-requester request pending; bit i belongs to requester i.
REQ-006 req_a  input  32  packed operand A; requester i uses bits [8i+7:8i].
REQ-007 req_b  input  32  packed operand B; same packing as req_a.
REQ-008 req_ready  output  4  one-hot acceptance pulse; request i is consumed in the cycle where req_valid[i] and req_ready[i] are both 1.
REQ-009 resp_valid  output  4  one-hot response pulse to the owning requester.
REQ-010 resp_result  output  16  product; valid only while any resp_valid bit is 1.
REQ-011 resp_err  output  1  timeout flag; valid only while any resp_valid bit is 1.
REQ-012 mul_start  output  1  one-cycle start pulse to the shared 8x8 multiplier.
REQ-013 mul_a, mul_b  output  8 each  operands to the multiplier, held stable from ISSUE through RESP.
REQ-014 mul_done  input  1  multiplier completion pulse.
REQ-015 mul_result  input  16  multiplier product, sampled only when mul_done is 1.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 grant_id  output  2  index of the current owner; holds the last owner in IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT and RESP, and exactly one operation SHALL be in flight at a time.
REQ-019 IDLE, no req_valid bit set: the FSM SHALL stay in IDLE with req_ready = 0.
REQ-020 IDLE, any req_valid bit set: the arbiter SHALL select winner g by round-robin, with search order last_grant+1, +2, +3, +4 (mod 4).
REQ-021 In that same IDLE cycle it SHALL drive req_ready = one-hot(g) combinationally, latch req_a/req_b slice g into the operand registers, set grant_id = g, and go to ISSUE.
REQ-022 last_grant SHALL reset to 3, so requester 0 has first priority after reset, and SHALL update to g on acceptance.
REQ-023 ISSUE SHALL assert mul_start = 1 for exactly one cycle, clear the wait counter, and go to WAIT.
REQ-024 WAIT, mul_done = 1: the block SHALL capture mul_result, set err = 0 and go to RESP.
REQ-025 WAIT, mul_done = 0: the wait counter SHALL increment each cycle; when it reaches TIMEOUT the block SHALL capture result 0, set err = 1 and go to RESP.
REQ-026 RESP SHALL assert resp_valid = one-hot(grant_id) for exactly one cycle with the registered resp_result/resp_err, then return to IDLE.
REQ-027 No new request SHALL be accepted in RESP.
REQ-028 With a 4-cycle multiplier (start sampled into its first stage, done one cycle after its third stage), acceptance in cycle 0 SHALL give mul_start in cycle 1, mul_done in cycle 5 and resp_valid in cycle 6, for a throughput of one operation per 7 cycles.
REQ-029 mul_done arriving in any state other than WAIT, including a late done after a timeout, SHALL be ignored.
REQ-030 A requester deasserting req_valid before acceptance SHALL lose its request with no side effect.
REQ-031 Changes on req_a/req_b after acceptance SHALL have no effect on the operation in flight.
REQ-032 req_ready and resp_valid SHALL never have more than one bit set, and neither SHALL be asserted in the same cycle as mul_start.
REQ-033 Product width SHALL be 16 bits unsigned; 8'hFF x 8'hFF = 16'hFE01 with no truncation.

Reset
REQ-034 With rst_n = 0 at a rising edge, in any state including mid-WAIT, the FSM SHALL go to IDLE.
REQ-035 That reset SHALL clear req_ready, resp_valid, resp_result, resp_err, mul_start, mul_a, mul_b, busy, grant_id and the wait counter to 0, and set last_grant to 3.
REQ-036 No resp_valid SHALL ever be emitted for an operation interrupted by reset.
REQ-037 For the first cycle after rst_n rises, req_ready SHALL follow req_valid under REQ-020 and REQ-021.

Verification
REQ-038 Single request: req0 with a=8'd12, b=8'd10 accepted in cycle 0 -> mul_start in cycle 1; resp_valid = 4'b0001 with resp_result = 16'd120 and resp_err = 0 in cycle 6.
REQ-039 Fairness: all four req_valid held high from reset -> grant order 0,1,2,3,0; each requester gets exactly one response per 28 cycles.
REQ-040 Boundary: req2 with a = b = 8'hFF -> resp_result = 16'hFE01 on resp_valid = 4'b0100; a=0, b=8'hFF -> 16'h0000.
REQ-041 Timeout: mul_done tied to 0, TIMEOUT = 15 -> resp_valid with resp_err = 1 and resp_result = 0 exactly 15 WAIT cycles after mul_start; a later mul_done pulse is ignored.
REQ-042 Reset mid-operation: rst_n = 0 during WAIT -> the next cycle is IDLE with all outputs 0 and no resp_valid; the next request goes to requester 0 first.
REQ-043 Operand stability: change req_a[7:0] the cycle after acceptance -> mul_a unchanged and result computed from the original operands.
